// File: rtl/internal_memory_pkg.sv
// Shared constants and response payload type for the multi-channel internal memory.
package internal_memory_pkg;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  localparam int unsigned MaxChanIdxW = 3;
  localparam int unsigned MaxTagW     = 64;

  function automatic int unsigned data_width(input int unsigned bytes);
    return 8 * bytes;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [MaxChanIdxW-1:0] chan;
    logic [MaxTagW-1:0]     tag;
  } rsp_t;

endpackage

// File: rtl/internal_memory_arb_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; the pointer moves past each winner.
module rr_arbiter
  import internal_memory_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N-1:0]                        req,
  output logic [N-1:0]                        gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] rr;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;
  logic            found;

  // First requester at or after the pointer wins; nothing is granted in reset.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(rr) + k) % N;
      cand_idx = IdxW'(cand);
      if (rst_n && !found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (|gnt) begin
      rr <= (32'(gnt_idx) == N - 1) ? '0 : IdxW'(32'(gnt_idx) + 32'd1);
    end
  end

endmodule

// File: rtl/internal_memory_arb.sv
// Single-port SRAM shared by several requesters through a round-robin arbiter,
// with active-low byte-enable writes and tagged, optionally double-registered read returns.
module internal_memory_arb
  import internal_memory_pkg::*;
#(
  parameter int unsigned DataBytes = 8,
  parameter int unsigned AddrWidth = 15,
  parameter int unsigned TagWidth  = 21,
  parameter int unsigned Channels  = 2,
  parameter int unsigned OutReg    = 0
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic [Channels-1:0]                       ACT,
  input  logic [Channels-1:0]                       CMD,
  input  logic [Channels-1:0][AddrWidth-1:0]        ADDR,
  input  logic [Channels-1:0][DataBytes-1:0]        BE,
  input  logic [Channels-1:0][8*DataBytes-1:0]      DI,
  input  logic [Channels-1:0][TagWidth-1:0]         TI,
  output logic [Channels-1:0]                       NEXT,
  output logic [Channels-1:0]                       DRDY,
  output logic [8*DataBytes-1:0]                    DO,
  output logic [TagWidth-1:0]                       TO
);

  localparam int unsigned DW    = data_width(DataBytes);
  localparam int unsigned IdxW  = (Channels > 1) ? $clog2(Channels) : 1;
  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Channels-1:0] gnt;
  logic [IdxW-1:0]     gidx;

  rr_arbiter #(.N(Channels)) u_arb (
    .clk    (CLK),
    .rst_n  (RESET),
    .req    (ACT),
    .gnt    (gnt),
    .gnt_idx(gidx)
  );

  assign NEXT = gnt;

  logic                 sel_cmd;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataBytes-1:0] sel_be;
  logic [DW-1:0]        sel_di;
  logic [TagWidth-1:0]  sel_ti;
  logic                 rd_en;
  logic                 wr_en;
  logic [DW-1:0]        wmask;

  assign sel_cmd  = CMD[gidx];
  assign sel_addr = ADDR[gidx];
  assign sel_be   = BE[gidx];
  assign sel_di   = DI[gidx];
  assign sel_ti   = TI[gidx];
  assign rd_en    = (|gnt) && (sel_cmd == CMD_READ);
  assign wr_en    = (|gnt) && (sel_cmd == CMD_WRITE);

  for (genvar b = 0; b < DataBytes; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{~sel_be[b]}};
  end

  logic [DW-1:0] mem [Depth];

  // Array contents survive reset; only enabled bytes change.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[sel_addr] <= (mem[sel_addr] & ~wmask) | (sel_di & wmask);
    end
  end

  logic [DW-1:0] rd_q;
  rsp_t          s1;

  // First stage: array read plus the response descriptor, held between reads.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_q <= '0;
      s1   <= '0;
    end else begin
      s1.valid <= rd_en;
      if (rd_en) begin
        rd_q    <= mem[sel_addr];
        s1.chan <= MaxChanIdxW'(gidx);
        s1.tag  <= MaxTagW'(sel_ti);
      end
    end
  end

  rsp_t          out_rsp;
  logic [DW-1:0] out_data;

  if (OutReg != 0) begin : g_oreg
    rsp_t          s2;
    logic [DW-1:0] do_q;

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        s2   <= '0;
        do_q <= '0;
      end else begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.chan <= s1.chan;
          s2.tag  <= s1.tag;
          do_q    <= rd_q;
        end
      end
    end

    assign out_rsp  = s2;
    assign out_data = do_q;
  end else begin : g_noreg
    assign out_rsp  = s1;
    assign out_data = rd_q;
  end

  // Outputs read as zero for as long as reset is held, not just after the reset edge.
  assign DRDY = (RESET && out_rsp.valid) ? Channels'(8'd1 << out_rsp.chan) : '0;
  assign DO   = out_data & {DW{RESET}};
  assign TO   = TagWidth'(out_rsp.tag) & {TagWidth{RESET}};

endmodule

// File: tb/tb_internal_memory_arb.sv
// Scoreboard bench for internal_memory_arb: OutReg=0 and OutReg=1 instances share the stimulus.
module tb_internal_memory_arb;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [1:0]        ACT, CMD;
  logic [1:0][14:0]  ADDR;
  logic [1:0][7:0]   BE;
  logic [1:0][63:0]  DI;
  logic [1:0][20:0]  TI;

  logic [1:0]  next0, drdy0, next1, drdy1;
  logic [63:0] do0, do1;
  logic [20:0] to0, to1;

  internal_memory_arb #(.OutReg(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .CMD(CMD), .ADDR(ADDR), .BE(BE), .DI(DI), .TI(TI),
    .NEXT(next0), .DRDY(drdy0), .DO(do0), .TO(to0)
  );

  internal_memory_arb #(.OutReg(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .CMD(CMD), .ADDR(ADDR), .BE(BE), .DI(DI), .TI(TI),
    .NEXT(next1), .DRDY(drdy1), .DO(do1), .TO(to1)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  drdy;
    logic [63:0] data;
    logic [20:0] tag;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Called just after a read grant edge: latency 1 for OutReg=0, 2 for OutReg=1.
  task automatic push_rd(input int ch, input logic [63:0] data, input logic [20:0] tag);
    q0.push_back('{drdy: 2'(1 << ch), data: data, tag: tag, cyc: cyc});
    q1.push_back('{drdy: 2'(1 << ch), data: data, tag: tag, cyc: cyc + 1});
  endtask

  task automatic chk_next(input string name, input logic [1:0] want);
    chk({name, "_next0"}, 64'(next0), 64'(want));
    chk({name, "_next1"}, 64'(next1), 64'(want));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_next(name, 2'b00);
    chk({name, "_drdy0"}, 64'(drdy0), 64'd0);
    chk({name, "_do0"}, do0, 64'd0);
    chk({name, "_to0"}, 64'(to0), 64'd0);
    chk({name, "_drdy1"}, 64'(drdy1), 64'd0);
    chk({name, "_do1"}, do1, 64'd0);
    chk({name, "_to1"}, 64'(to1), 64'd0);
  endtask

  // Single-channel request issued at posedge+1; returns at posedge+1 after its grant edge.
  task automatic single(input int ch, input logic cmd, input logic [14:0] a, input logic [7:0] be,
                        input logic [63:0] d, input logic [20:0] t, input logic [63:0] exp_data);
    ACT = 2'b00;
    ACT[ch] = 1'b1; CMD[ch] = cmd; ADDR[ch] = a; BE[ch] = be; DI[ch] = d; TI[ch] = t;
    @(negedge CLK);
    chk_next("single", 2'(1 << ch));
    @(posedge CLK); #1;
    if (cmd) push_rd(ch, exp_data, t);
    ACT = 2'b00;
  endtask

  task automatic do_reset(input int n);
    ACT = 2'b00;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    ACT = 2'b11;
    repeat (n) begin
      @(negedge CLK);
      chk_reset_outputs("in_reset");
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    ACT = 2'b00;
  endtask

  // Response monitors: pop and compare whenever a DRDY pulse is visible.
  always @(negedge CLK) begin
    if (drdy0 !== 2'b00) begin
      compared++;
      if (q0.size() == 0) begin
        mismatched++;
        $display("FAIL rsp0_unexpected: got drdy=%b do=%h to=%h at cycle %0d, required no response", drdy0, do0, to0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (drdy0 !== e0.drdy || do0 !== e0.data || to0 !== e0.tag || cyc != e0.cyc) begin
          mismatched++;
          $display("FAIL rsp0: got drdy=%b do=%h to=%h cyc=%0d, required drdy=%b do=%h to=%h cyc=%0d",
                   drdy0, do0, to0, cyc, e0.drdy, e0.data, e0.tag, e0.cyc);
        end
      end
    end
    if (drdy1 !== 2'b00) begin
      compared++;
      if (q1.size() == 0) begin
        mismatched++;
        $display("FAIL rsp1_unexpected: got drdy=%b do=%h to=%h at cycle %0d, required no response", drdy1, do1, to1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (drdy1 !== e1.drdy || do1 !== e1.data || to1 !== e1.tag || cyc != e1.cyc) begin
          mismatched++;
          $display("FAIL rsp1: got drdy=%b do=%h to=%h cyc=%0d, required drdy=%b do=%h to=%h cyc=%0d",
                   drdy1, do1, to1, cyc, e1.drdy, e1.data, e1.tag, e1.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0;
    ACT = 2'b11; CMD = 2'b11; ADDR = '0; BE = '1; DI = '0; TI = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("por");
    @(posedge CLK); #1;
    RESET = 1'b1;
    ACT = 2'b00;

    // Full write then tagged read on ch0.
    single(0, 1'b0, 15'h10, 8'h00, 64'h1122334455667788, 21'h0, 64'h0);
    single(0, 1'b1, 15'h10, 8'hFF, 64'h0, 21'h5, 64'h1122334455667788);

    // Partial write: only the low four bytes are enabled.
    single(0, 1'b0, 15'h10, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 21'h0, 64'h0);
    single(0, 1'b1, 15'h10, 8'hFF, 64'h0, 21'h6, 64'h11223344FFFFFFFF);

    // All-ones BE consumes a grant but leaves the word untouched.
    single(1, 1'b0, 15'h10, 8'hFF, 64'h0, 21'h0, 64'h0);

    for (int k = 0; k < 4; k++)
      single(0, 1'b0, 15'(k), 8'h00, 64'hA0 + 64'(k), 21'h0, 64'h0);

    // Four back-to-back ch1 reads.
    for (int k = 0; k < 4; k++) begin
      ACT = 2'b10; CMD[1] = 1'b1; ADDR[1] = 15'(k); TI[1] = 21'h10 + 21'(k);
      @(negedge CLK);
      chk_next("b2b", 2'b10);
      @(posedge CLK); #1;
      push_rd(1, 64'hA0 + 64'(k), 21'h10 + 21'(k));
    end
    ACT = 2'b00;
    single(1, 1'b1, 15'h10, 8'hFF, 64'h0, 21'h7, 64'h11223344FFFFFFFF);

    // Both channels reading continuously from reset alternate grants.
    do_reset(2);
    ACT = 2'b11; CMD = 2'b11; ADDR[0] = 15'h10; ADDR[1] = 15'h2; TI[0] = 21'h20; TI[1] = 21'h30;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk_next("rr", (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge CLK); #1;
      if (k % 2 == 0) begin
        push_rd(0, 64'h11223344FFFFFFFF, TI[0]);
        TI[0] = TI[0] + 21'h1;
      end else begin
        push_rd(1, 64'hA2, TI[1]);
        TI[1] = TI[1] + 21'h1;
      end
    end
    ACT = 2'b00;

    // ch0 writes addr 7, ch1 reads it on the following grant.
    ACT = 2'b11;
    CMD[0] = 1'b0; ADDR[0] = 15'h7; BE[0] = 8'h00; DI[0] = 64'hDEADBEEFCAFEF00D;
    CMD[1] = 1'b1; ADDR[1] = 15'h7; TI[1] = 21'h77;
    @(negedge CLK);
    chk_next("wr_rd_w", 2'b01);
    @(posedge CLK); #1;
    ACT[0] = 1'b0;
    @(negedge CLK);
    chk_next("wr_rd_r", 2'b10);
    @(posedge CLK); #1;
    push_rd(1, 64'hDEADBEEFCAFEF00D, 21'h77);
    ACT = 2'b00;
    repeat (3) @(posedge CLK);
    #1;

    // Reset asserted the cycle after a read grant discards that read.
    ACT = 2'b01; CMD[0] = 1'b1; ADDR[0] = 15'h10; TI[0] = 21'h9;
    @(negedge CLK);
    chk_next("mid_grant", 2'b01);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk_reset_outputs("mid_reset");
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    ACT = 2'b00;
    single(0, 1'b1, 15'h10, 8'hFF, 64'h0, 21'hA, 64'h11223344FFFFFFFF);
    single(0, 1'b1, 15'h7, 8'hFF, 64'h0, 21'hB, 64'hDEADBEEFCAFEF00D);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
